// File: rtl/detector_arbiter.sv
// rtl/detector_arbiter.sv - round-robin arbiter time-sharing one "1101" Mealy detector across 4 channels
// Each channel keeps a 2-bit saved detector context; hits are counted per channel.
module detector_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       bit_in,
  input  logic [3:0]       flush,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [3:0]       gnt,
  output logic             z,
  output logic [1:0]       z_ch,
  output logic [CNT_W-1:0] cnt_out,
  output logic             busy
);

  typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;

  det_state_t       r_ctx [4];
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt [4];
  logic             r_z;
  logic [1:0]       r_z_ch;
  logic             r_busy;

  logic       w_any;
  logic [1:0] w_sel;
  logic [1:0] w_idx;
  det_state_t w_cur;
  det_state_t w_nxt;
  logic       w_bit;
  logic       w_hit;

  // Walk from farthest to nearest so the last match is the first requester after ptr.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
    if (!rst) begin
      w_any = 1'b0;
    end
  end

  assign gnt = w_any ? (4'b0001 << w_sel) : 4'b0000;

  always_comb begin
    w_cur = r_ctx[w_sel];
    w_bit = bit_in[w_sel];
    w_nxt = S0;
    case (w_cur)
      S0:      w_nxt = w_bit ? S1 : S0;
      S1:      w_nxt = w_bit ? S2 : S0;
      S2:      w_nxt = w_bit ? S2 : S3;
      S3:      w_nxt = w_bit ? S1 : S0;
      default: w_nxt = S0;
    endcase
    // A flush on the granted channel suppresses the hit but not the consumption.
    w_hit = w_any && (w_cur == S3) && w_bit && !flush[w_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_ctx[i] <= S0;
        r_cnt[i] <= '0;
      end
      r_ptr  <= 2'd0;
      r_z    <= 1'b0;
      r_z_ch <= 2'd0;
      r_busy <= 1'b0;
    end else begin
      if (w_any) begin
        r_ctx[w_sel] <= w_nxt;
        r_ptr        <= w_sel + 2'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (flush[i]) begin
          r_ctx[i] <= S0;
        end
        if (cnt_clr) begin
          r_cnt[i] <= '0;
        end else if (w_hit && (w_sel == 2'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_z    <= w_hit;
      r_busy <= w_any;
      if (w_hit) begin
        r_z_ch <= w_sel;
      end
    end
  end

  assign z       = r_z;
  assign z_ch    = r_z_ch;
  assign busy    = r_busy;
  assign cnt_out = r_cnt[cnt_sel];

endmodule

// File: tb/tb_detector_arbiter.sv
// tb/tb_detector_arbiter.sv - scoreboard bench for detector_arbiter
// Reference detector is a sliding 4-bit window per channel rather than a state table.
module tb_detector_arbiter;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req, bit_in, flush;
  logic          cnt_clr;
  logic [1:0]    cnt_sel;
  logic [3:0]    gnt;
  logic          z;
  logic [1:0]    z_ch;
  logic [CW-1:0] cnt_out;
  logic          busy;

  detector_arbiter #(.CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .flush(flush),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .gnt(gnt), .z(z), .z_ch(z_ch),
    .cnt_out(cnt_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [2:0] m_hist [4];
  int         m_ptr;
  int         m_cnt [4];
  int         m_zch;
  logic       m_busy;
  int         q_zch [$];

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = 3'b000;
      m_cnt[i]  = 0;
    end
    m_ptr  = 0;
    m_zch  = 0;
    m_busy = 1'b0;
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] bi,
                      input logic [3:0] fl, input logic clr);
    int         g;
    logic [3:0] exp_gnt;
    logic [3:0] win;
    logic       hit;
    @(negedge clk);
    rst     = r;
    req     = rq;
    bit_in  = bi;
    flush   = fl;
    cnt_clr = clr;
    cnt_sel = 2'($urandom_range(0, 3));
    #1;
    g = -1;
    if (r) begin
      for (int k = 3; k >= 0; k--) begin
        if (rq[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    exp_gnt = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("gnt", int'(gnt), int'(exp_gnt));
    chk("cnt_out", int'(cnt_out), m_cnt[cnt_sel]);
    hit = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        win       = {m_hist[g], bi[g]};
        hit       = (win == 4'b1101) && !fl[g];
        m_hist[g] = win[2:0];
        m_ptr     = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (fl[i]) m_hist[i] = 3'b000;
        if (clr) m_cnt[i] = 0;
      end
      if (hit) begin
        q_zch.push_back(g);
        if (!clr && m_cnt[g] < CMAX) m_cnt[g]++;
      end
      m_busy = (g >= 0);
    end
    @(posedge clk);
    #1;
    chk("z", int'(z), int'(q_zch.size() != 0));
    if (q_zch.size() != 0) m_zch = q_zch.pop_front();
    chk("z_ch", int'(z_ch), m_zch);
    chk("busy", int'(busy), int'(m_busy));
  endtask

  task automatic send(input int ch, input logic b);
    step(1'b1, 4'b0001 << ch, {4{b}}, 4'b0000, 1'b0);
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt_sel = 2'(i);
      req     = 4'b0000;
      #1;
      chk(tag, int'(cnt_out), m_cnt[i]);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0);
  endtask

  logic [6:0] s1101101;
  logic [3:0] s1101;
  int         hits_seen;

  initial begin
    rst = 1'b0; req = '0; bit_in = '0; flush = '0; cnt_clr = 1'b0; cnt_sel = '0;
    model_reset();
    do_reset();
    chk("rst_z", int'(z), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_zch", int'(z_ch), 0);
    check_counters("rst_cnt");

    // single channel overlapping stream
    s1101101  = 7'b1101101;
    hits_seen = 0;
    for (int i = 6; i >= 0; i--) begin
      send(0, s1101101[i]);
      if (z) hits_seen++;
    end
    chk("single_hits", hits_seen, 2);
    check_counters("single_cnt");

    // fairness from ptr=0
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);

    // interleaved ch1/ch2
    do_reset();
    s1101 = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      send(1, s1101[i]);
      send(2, s1101[i]);
    end
    check_counters("inter_cnt");

    // flush collision with ch0 in S3
    do_reset();
    send(0, 1'b1); send(0, 1'b1); send(0, 1'b0);
    step(1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0);
    chk("flush_z", int'(z), 0);
    for (int i = 3; i >= 0; i--) send(0, s1101[i]);
    check_counters("flush_cnt");

    // saturation then clear with coincident hit
    do_reset();
    for (int i = 3; i >= 0; i--) send(3, s1101[i]);
    for (int n = 0; n < 3; n++) begin
      send(3, 1'b1); send(3, 1'b0); send(3, 1'b1);
    end
    check_counters("sat_cnt");
    send(3, 1'b1); send(3, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1);
    chk("clr_z", int'(z), 1);
    check_counters("clr_cnt");

    // reset mid-sequence discards partial match
    do_reset();
    send(0, 1'b1); send(0, 1'b1); send(0, 1'b0);
    step(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    send(0, 1'b1);
    chk("midrst_z", int'(z), 0);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    check_counters("midrst_cnt");

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 4'($urandom), 4'($urandom),
           (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000),
           ($urandom_range(0, 29) == 0));
    end
    check_counters("rand_cnt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/detector_arbiter.md
DETECTOR_ARBITER -- requirements
Module: detector_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-channel hit counter.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-low.
REQ-004 Port: req  input  4  per-channel request; req[i]=1 means bit_in[i] holds a valid serial bit.
REQ-005 Port: bit_in  input  4  per-channel serial data bit, qualified by req[i].
REQ-006 Port: flush  input  4  per-channel context clear request.
REQ-007 Port: cnt_clr  input  1  clears all hit counters.
REQ-008 Port: cnt_sel  input  2  selects which channel's counter drives cnt_out.
REQ-009 Port: gnt  output  4  one-hot combinational grant; bit_in[i] is consumed on an edge where gnt[i]=1.
REQ-010 Port: z  output  1  registered detection pulse.
REQ-011 Port: z_ch  output  2  channel index for z; valid only when z=1.
REQ-012 Port: cnt_out  output  CNT_W  combinational read of counter[cnt_sel].
REQ-013 Port: busy  output  1  registered; 1 if a grant was issued in the previous cycle.

Function
REQ-014 The block SHALL time-share one Mealy "1101" overlapping detector across 4 channels, with a 2-bit saved context per channel.
REQ-015 Detector states SHALL be S0 (idle), S1 (seen 1), S2 (seen 11) and S3 (seen 110).
REQ-016 Transitions SHALL be: S0: 1->S1, 0->S0; S1: 1->S2, 0->S0; S2: 1->S2, 0->S3; S3: 1->S1 with hit, 0->S0.
REQ-017 A hit SHALL occur only on the S3 input-1 transition; overlap is preserved (1101101 gives 2 hits).
REQ-018 The arbiter SHALL be round-robin with pointer ptr (2 bits); gnt SHALL select the first requesting channel found searching ptr, ptr+1, ... mod 4.
REQ-019 Grant SHALL be combinational, at most one bit set, and gnt=0 when req=0.
REQ-020 On a clock edge with gnt[i]=1, ptr SHALL become (i+1) mod 4; with no grant, ptr SHALL be unchanged.
REQ-021 On a grant to channel i, the block SHALL load context[i], apply bit_in[i], and write back the next state in the same edge.
REQ-022 Ungranted channels' contexts SHALL be unchanged.
REQ-023 A hit on channel i SHALL produce z=1 and z_ch=i in the cycle after consumption, for exactly one cycle; otherwise z=0 and z_ch holds its last value.
REQ-024 A hit on channel i SHALL increment counter[i], saturating at 2^CNT_W-1 (no wrap).
REQ-025 flush[i] SHALL set context[i] to S0 at the edge.
REQ-026 If flush[i] coincides with a grant to channel i, flush SHALL win: context[i]=S0, no hit, no count; the bit is still consumed and ptr still advances.
REQ-027 cnt_clr SHALL zero all counters; a coincident hit SHALL not increment (clear wins), though z still pulses.
REQ-028 A requester SHALL hold req[i] and bit_in[i] stable until it sees gnt[i]=1 at an edge; deasserting req[i] earlier drops the request without any state change.

Reset
REQ-029 When rst=0 at a rising edge: all contexts=S0, ptr=0, all counters=0, z=0, z_ch=0, busy=0.
REQ-030 gnt SHALL be forced to 0 while rst=0, and no bit is consumed.
REQ-031 Reset asserted mid-sequence SHALL discard all partial matches; after release, a fresh full "1101" is needed for a hit.

Verification
REQ-032 Single channel: req=0001, bit_in[0] stream 1,1,0,1,1,0,1 -> z pulses on 2 cycles (after the 4th and 7th bits), z_ch=0, counter[0]=2.
REQ-033 Fairness: req=1111 held for 8 cycles, ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-034 Interleave: ch1 and ch2 each send 1101 alternately, with ch2 sending 1,1,0,1 -> each context is tracked independently; 2 hits with z_ch=1 then 2; counter[1]=counter[2]=1.
REQ-035 Flush collision: ch0 in S3, flush[0]=1 and gnt[0] with bit 1 in the same cycle -> z=0, counter[0] unchanged, context[0]=S0.
REQ-036 Saturation and clear: CNT_W=2, 4 hits on ch3 -> cnt_out=3 with cnt_sel=3; then cnt_clr coincident with a hit -> z=1, cnt_out=0.
REQ-037 Reset: ch0 after 1,1,0 in progress, rst=0 for one cycle, then bit 1 -> no z; counters=0; ptr=0.
